and2_req_arbiter: RTL and testbench



---
 rtl/and2_arb_pkg.sv | 12 +
 rtl/rr_picker.sv | 41 ++++
 rtl/and2_req_arbiter.sv | 109 ++++++++++
 tb/tb_and2_req_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/and2_arb_pkg.sv
// Shared types and helpers for the and2 request arbiter.
//   arb_state_e : arbiter FSM states
//   id_w(n)     : width of an index into n items, never less than 1 bit
package and2_arb_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} arb_state_e;

  function automatic int unsigned id_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: selects the first set req_valid bit at or after rr_ptr, wrapping.
//   req_valid  : per-requester valid
//   rr_ptr     : index with highest priority this round
//   gnt_onehot : one-hot grant (all zero when nothing is valid)
//   gnt_idx    : binary index of the granted requester
//   any_valid  : at least one requester is valid
module rr_picker import and2_arb_pkg::*; #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [id_w(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]       gnt_onehot,
  output logic [id_w(NUM_REQ)-1:0] gnt_idx,
  output logic                     any_valid
);

  localparam int unsigned IdW = id_w(NUM_REQ);

  logic [IdW-1:0] idx;
  logic           found;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    idx        = '0;
    found      = 1'b0;
    // Walk offsets from rr_ptr; the first valid one wins.
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = IdW'((32'(rr_ptr) + off) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
    if (found) begin
      gnt_onehot[gnt_idx] = 1'b1;
    end
    any_valid = found;
  end

endmodule

// File: rtl/and2_req_arbiter.sv
// Shares one registered and2 datapath between NUM_REQ requesters.
// Requesters are granted round-robin; the granted operands are registered onto and_a/and_b,
// the result is sampled from and_y after RES_LAT cycles and returned as a one-cycle strobe
// tagged with the requester ID.
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   req_valid/a/b     : per-requester operand offer
//   req_ready         : one-hot accept, combinational in IDLE
//   and_a, and_b      : operands to the and2 datapath (held until the next grant)
//   and_y             : and2 result, sampled only in RESP
//   rsp_valid/id/y    : result strobe, requester ID and captured result
module and2_req_arbiter import and2_arb_pkg::*; #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned RES_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_a,
  input  logic [NUM_REQ-1:0]       req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     and_a,
  output logic                     and_b,
  input  logic                     and_y,
  output logic                     rsp_valid,
  output logic [id_w(NUM_REQ)-1:0] rsp_id,
  output logic                     rsp_y
);

  localparam int unsigned IdW  = id_w(NUM_REQ);
  localparam int unsigned LatW = id_w(RES_LAT);

  arb_state_e     state;
  logic [IdW-1:0] rr_ptr;
  logic [IdW-1:0] cur_id;
  logic [IdW-1:0] next_ptr;
  logic [LatW-1:0] lat_cnt;

  logic [NUM_REQ-1:0] gnt_onehot;
  logic [IdW-1:0]     gnt_idx;
  logic               any_valid;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_picker (
    .req_valid  (req_valid),
    .rr_ptr     (rr_ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any_valid  (any_valid)
  );

  // The picker only grants valid bits, so a non-zero req_ready always completes a handshake.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && !rst) begin
      req_ready = gnt_onehot;
    end
  end

  always_comb begin
    next_ptr = '0;
    if (cur_id != IdW'(NUM_REQ - 1)) begin
      next_ptr = cur_id + IdW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_id    <= '0;
      lat_cnt   <= '0;
      and_a     <= 1'b0;
      and_b     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_valid) begin
            and_a   <= req_a[gnt_idx];
            and_b   <= req_b[gnt_idx];
            cur_id  <= gnt_idx;
            lat_cnt <= LatW'(RES_LAT - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            state <= RESP;
          end else begin
            lat_cnt <= lat_cnt - LatW'(1);
          end
        end
        RESP: begin
          rsp_y     <= and_y;
          rsp_id    <= cur_id;
          rsp_valid <= 1'b1;
          rr_ptr    <= next_ptr;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_and2_req_arbiter.sv
module tb_and2_req_arbiter;

  localparam int NR  = 4;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid, req_a, req_b, req_ready;
  logic          and_a, and_b, and_y;
  logic          rsp_valid, rsp_y;
  logic [1:0]    rsp_id;

  int checks = 0;
  int errors = 0;

  and2_req_arbiter #(
    .NUM_REQ (NR),
    .RES_LAT (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .and_a     (and_a),
    .and_b     (and_b),
    .and_y     (and_y),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y)
  );

  always #5 clk = ~clk;

  // Behavioural and2 datapath with one registered stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) and_y <= 1'b0;
    else     and_y <= and_a & and_b;
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic int oh2idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  typedef struct {
    logic          rst;
    logic [NR-1:0] valid, a, b, exp_ready;
    logic          exp_rv;
    logic [1:0]    exp_id;
    logic          exp_y;
  } vec_t;

  vec_t vecs[18];

  typedef struct {
    int   due;
    int   id;
    logic y;
  } rsp_t;

  rsp_t q[$];
  rsp_t r;

  int   grants[4];
  int   ng, bad, seen0, g, c, next_free, ptr, last_id;
  bit   have_last;
  logic last_y;
  logic [NR-1:0] exp_ready;

  initial begin
    // Single request, then (after reset) all four requesters with AB = {11,10,01,11}.
    vecs[0]  = '{1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0, 1'b0};
    vecs[1]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[2]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[3]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b1};
    vecs[4]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[5]  = '{1'b0, 4'b1111, 4'b1011, 4'b1101, 4'b0001, 1'b0, 2'd0, 1'b0};
    vecs[6]  = '{1'b0, 4'b1111, 4'b1011, 4'b1101, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[7]  = '{1'b0, 4'b1111, 4'b1011, 4'b1101, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[8]  = '{1'b0, 4'b1111, 4'b1011, 4'b1101, 4'b0010, 1'b1, 2'd0, 1'b1};
    vecs[9]  = '{1'b0, 4'b1111, 4'b1011, 4'b1101, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[10] = '{1'b0, 4'b1111, 4'b1011, 4'b1101, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[11] = '{1'b0, 4'b1111, 4'b1011, 4'b1101, 4'b0100, 1'b1, 2'd1, 1'b0};
    vecs[12] = '{1'b0, 4'b1111, 4'b1011, 4'b1101, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[13] = '{1'b0, 4'b1111, 4'b1011, 4'b1101, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[14] = '{1'b0, 4'b1111, 4'b1011, 4'b1101, 4'b1000, 1'b1, 2'd2, 1'b0};
    vecs[15] = '{1'b0, 4'b1111, 4'b1011, 4'b1101, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[16] = '{1'b0, 4'b1111, 4'b1011, 4'b1101, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[17] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd3, 1'b1};

    // Reset state.
    rst = 1'b1;
    req_valid = 4'b1111;
    req_a = '1;
    req_b = '1;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_and_a", and_a, 0);
    chk("rst_and_b", and_b, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_y", rsp_y, 0);
    do_reset();

    // Table-driven vectors.
    for (int i = 0; i < 18; i++) begin
      rst = vecs[i].rst;
      req_valid = vecs[i].valid;
      req_a = vecs[i].a;
      req_b = vecs[i].b;
      #1;
      chk($sformatf("vec%0d_ready", i), req_ready, vecs[i].exp_ready);
      chk($sformatf("vec%0d_rsp_valid", i), rsp_valid, vecs[i].exp_rv);
      if (vecs[i].exp_rv) begin
        chk($sformatf("vec%0d_rsp_id", i), rsp_id, vecs[i].exp_id);
        chk($sformatf("vec%0d_rsp_y", i), rsp_y, vecs[i].exp_y);
      end
      tick();
    end

    // Fairness: serve 2, then 0 and 2 stay valid -> 0,2,0,2.
    do_reset();
    req_valid = 4'b0100;
    #1;
    chk("fair_first", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0101;
    ng = 0;
    for (int n = 0; n < 40 && ng < 4; n++) begin
      #1;
      if (req_ready != 0) begin
        grants[ng] = oh2idx(req_ready);
        ng++;
      end
      tick();
    end
    chk("fair_count", ng, 4);
    chk("fair_g0", grants[0], 0);
    chk("fair_g1", grants[1], 2);
    chk("fair_g2", grants[2], 0);
    chk("fair_g3", grants[3], 2);

    // Operands change during WAIT are ignored.
    do_reset();
    req_valid = 4'b0010;
    req_a = 4'b0010;
    req_b = 4'b0010;
    #1;
    chk("opchg_ready", req_ready, 4'b0010);
    tick();
    req_a = 4'b0000;
    req_valid = 4'b0000;
    #1;
    chk("opchg_and_a_wait", and_a, 1);
    tick();
    chk("opchg_and_a_resp", and_a, 1);
    tick();
    chk("opchg_rsp_valid", rsp_valid, 1);
    chk("opchg_rsp_id", rsp_id, 1);
    chk("opchg_rsp_y", rsp_y, 1);

    // Withdraw: req3 valid for one busy cycle only.
    do_reset();
    req_valid = 4'b0001;
    req_a = 4'b0001;
    req_b = 4'b0001;
    #1;
    chk("wd_ready", req_ready, 4'b0001);
    tick();
    req_valid = 4'b1000;
    #1;
    chk("wd_busy_ready", req_ready, 0);
    tick();
    req_valid = 4'b0000;
    bad = 0;
    seen0 = 0;
    for (int n = 0; n < 12; n++) begin
      #1;
      if (req_ready[3]) bad++;
      if (rsp_valid && rsp_id == 2'd3) bad++;
      if (rsp_valid && rsp_id == 2'd0) seen0++;
      tick();
    end
    chk("wd_no_req3", bad, 0);
    chk("wd_req0_served", seen0, 1);

    // Async reset in WAIT: abort, then restart with rr_ptr back at 0.
    do_reset();
    req_valid = 4'b0010;
    req_a = '0;
    req_b = '0;
    #1;
    chk("ar_g1", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    req_valid = 4'b0100;
    req_a = 4'b0100;
    req_b = 4'b0100;
    #1;
    chk("ar_g2", req_ready, 4'b0100);
    tick();
    chk("ar_wait_and_a", and_a, 1);
    rst = 1'b1;
    req_valid = 4'b0110;
    #1;
    chk("ar_and_a_clr", and_a, 0);
    chk("ar_and_b_clr", and_b, 0);
    chk("ar_rsp_valid_clr", rsp_valid, 0);
    chk("ar_no_grant_in_rst", req_ready, 0);
    bad = 0;
    for (int n = 0; n < 3; n++) begin
      tick();
      if (rsp_valid || req_ready != 0) bad++;
    end
    chk("ar_quiet_in_rst", bad, 0);
    rst = 1'b0;
    #1;
    chk("ar_restart_grant", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    chk("ar_restart_rsp_valid", rsp_valid, 1);
    chk("ar_restart_rsp_id", rsp_id, 1);

    // Randomised traffic against a timing/queue reference model.
    do_reset();
    c = 0;
    next_free = 0;
    ptr = 0;
    have_last = 0;
    q.delete();
    for (int n = 0; n < 600; n++) begin
      req_valid = NR'($urandom_range(0, 15));
      req_a = NR'($urandom_range(0, 15));
      req_b = NR'($urandom_range(0, 15));
      #1;
      exp_ready = '0;
      if (c >= next_free && req_valid != 0) begin
        g = -1;
        for (int k = 0; k < NR; k++) begin
          if (g < 0 && req_valid[(ptr + k) % NR]) g = (ptr + k) % NR;
        end
        exp_ready[g] = 1'b1;
        r.due = c + LAT + 2;
        r.id = g;
        r.y = req_a[g] & req_b[g];
        q.push_back(r);
        ptr = (g + 1) % NR;
        next_free = c + LAT + 2;
      end
      chk("rnd_ready", req_ready, exp_ready);
      if (q.size() > 0 && q[0].due == c) begin
        r = q.pop_front();
        chk("rnd_rsp_valid", rsp_valid, 1);
        chk("rnd_rsp_id", rsp_id, r.id);
        chk("rnd_rsp_y", rsp_y, r.y);
        have_last = 1;
        last_id = r.id;
        last_y = r.y;
      end else begin
        chk("rnd_rsp_idle", rsp_valid, 0);
        if (have_last) begin
          chk("rnd_hold_id", rsp_id, last_id);
          chk("rnd_hold_y", rsp_y, last_y);
        end
      end
      tick();
      c++;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
